// File: rtl/tag_ram_ctrl_pkg.sv
// Shared definitions for the tag RAM controller: FSM states, entry field
// layout helpers and default geometry.
package tag_ram_pkg;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        LOOKUP = 2'd2
    } state_t;

    localparam int DEF_AWIDTH = 3;
    localparam int DEF_DWIDTH = 7;

    // Entry layout: {valid, tag}; the tag fills everything below the valid bit.
    function automatic int twidth(input int dw);
        return dw - 1;
    endfunction

    function automatic int valid_bit(input int dw);
        return dw - 1;
    endfunction

    function automatic int tag_msb(input int dw);
        return dw - 2;
    endfunction

endpackage

// File: rtl/tag_ram_ctrl_if.sv
// Request/response, flush/init and RAM-side signals of the tag RAM controller.
// master = requester plus RAM side (bench), slave = the controller.
interface tag_ram_ctrl_if #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 7
);
    localparam int TWIDTH = DWIDTH - 1;

    logic              flush;
    logic              init_busy;
    logic              req_valid;
    logic              req_ready;
    logic [AWIDTH-1:0] req_index;
    logic [TWIDTH-1:0] req_tag;
    logic              req_alloc;
    logic              rsp_valid;
    logic              rsp_hit;
    logic [AWIDTH-1:0] rsp_index;
    logic [DWIDTH-1:0] rsp_old_entry;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_din;
    logic              mem_we;
    logic [DWIDTH-1:0] mem_dout;

    modport master (
        output flush, req_valid, req_index, req_tag, req_alloc, mem_dout,
        input  init_busy, req_ready, rsp_valid, rsp_hit, rsp_index, rsp_old_entry,
               mem_addr, mem_din, mem_we
    );

    modport slave (
        input  flush, req_valid, req_index, req_tag, req_alloc, mem_dout,
        output init_busy, req_ready, rsp_valid, rsp_hit, rsp_index, rsp_old_entry,
               mem_addr, mem_din, mem_we
    );
endinterface

// File: rtl/tag_ram_ctrl_compare.sv
// Combinational hit detection: entry valid bit set and stored tag equal.
module tag_compare
    import tag_ram_pkg::*;
#(
    parameter int DWIDTH = 7
) (
    input  logic [DWIDTH-1:0]         entry,
    input  logic [twidth(DWIDTH)-1:0] tag,
    output logic                      hit
);
    localparam int VALID_BIT = valid_bit(DWIDTH);
    localparam int TAG_MSB   = tag_msb(DWIDTH);

    assign hit = entry[VALID_BIT] && (entry[TAG_MSB:0] == tag);
endmodule

// File: rtl/tag_ram.sv
// Tag RAM controller: sweeps the RAM to invalid after reset/flush, then
// serves lookups (read, compare, optional allocate write) with a 2-cycle
// response latency against a synchronous-read RAM.
module tag_ram_ctrl
    import tag_ram_pkg::*;
#(
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int DWIDTH = DEF_DWIDTH
) (
    input  logic           clock,
    input  logic           reset,
    tag_ram_ctrl_if.slave  bus
);
    localparam int TWIDTH = twidth(DWIDTH);
    localparam int DEPTH  = 1 << AWIDTH;
    localparam logic [AWIDTH-1:0] LAST = AWIDTH'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] cnt_q;
    logic [AWIDTH-1:0] index_q;
    logic [TWIDTH-1:0] tag_q;
    logic              alloc_q;
    logic              flush_pend_q;

    logic              rsp_valid_q, rsp_hit_q;
    logic [AWIDTH-1:0] rsp_index_q;
    logic [DWIDTH-1:0] rsp_old_q;

    logic              hit;
    logic              we_c;
    logic [AWIDTH-1:0] addr_c;
    logic [DWIDTH-1:0] din_c;
    logic              ready_c;
    logic              busy_c;

    tag_compare #(.DWIDTH(DWIDTH)) u_cmp (
        .entry (bus.mem_dout),
        .tag   (tag_q),
        .hit   (hit)
    );

    // Next state and RAM/handshake outputs for the current state.
    always_comb begin
        state_d = state_q;
        we_c    = 1'b0;
        addr_c  = bus.req_index;
        din_c   = '0;
        ready_c = 1'b0;
        busy_c  = 1'b0;
        case (state_q)
            INIT: begin
                addr_c = cnt_q;
                we_c   = 1'b1;
                busy_c = 1'b1;
                // A flush here restarts the sweep, so never leave on that cycle.
                if (!bus.flush && cnt_q == LAST)
                    state_d = IDLE;
            end
            IDLE: begin
                ready_c = !bus.flush && !flush_pend_q;
                if (bus.flush || flush_pend_q)
                    state_d = INIT;
                else if (bus.req_valid)
                    state_d = LOOKUP;
            end
            LOOKUP: begin
                addr_c = index_q;
                if (!hit && alloc_q) begin
                    we_c  = 1'b1;
                    din_c = {1'b1, tag_q};
                end
                state_d = flush_pend_q ? INIT : IDLE;
            end
            default: state_d = INIT;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= INIT;
        else       state_q <= state_d;
    end

    // Sweep counter: runs only in INIT, wraps to 0 after the last entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                cnt_q <= '0;
        else if (state_q == INIT) cnt_q <= bus.flush ? '0 : cnt_q + 1'b1;
        else                      cnt_q <= '0;
    end

    // Remember a flush that arrived mid-lookup until the sweep begins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                                  flush_pend_q <= 1'b0;
        else if (state_d == INIT)                   flush_pend_q <= 1'b0;
        else if (bus.flush && state_q == LOOKUP)    flush_pend_q <= 1'b1;
    end

    // Capture the accepted request for the LOOKUP cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            index_q <= '0;
            tag_q   <= '0;
            alloc_q <= 1'b0;
        end else if (bus.req_valid && ready_c) begin
            index_q <= bus.req_index;
            tag_q   <= bus.req_tag;
            alloc_q <= bus.req_alloc;
        end
    end

    // Response registers: pulse valid after LOOKUP, otherwise hold fields.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_index_q <= '0;
            rsp_old_q   <= '0;
        end else begin
            rsp_valid_q <= (state_q == LOOKUP);
            if (state_q == LOOKUP) begin
                rsp_hit_q   <= hit;
                rsp_index_q <= index_q;
                rsp_old_q   <= bus.mem_dout;
            end
        end
    end

    // Reset must never let the INIT write enable reach the RAM.
    assign bus.mem_we        = we_c && !reset;
    assign bus.mem_addr      = addr_c;
    assign bus.mem_din       = din_c;
    assign bus.req_ready     = ready_c;
    assign bus.init_busy     = busy_c;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_hit       = rsp_hit_q;
    assign bus.rsp_index     = rsp_index_q;
    assign bus.rsp_old_entry = rsp_old_q;
endmodule

// File: tb/tb_tag_ram_ctrl.sv
// Bench for tag_ram_ctrl with a synchronous-read RAM model behind mem_*,
// a tag-store model and a per-cycle response checker.
module tb_tag_ram_ctrl;
    localparam int AW = 3;
    localparam int DW = 7;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   last_due = 0;

    tag_ram_ctrl_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    tag_ram_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Synchronous-read RAM: address registered, dout from the stored address.
    logic [DW-1:0] ram [1<<AW];
    logic [AW-1:0] ram_addr_q = '0;
    always @(posedge clock) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
        ram_addr_q <= bus.mem_addr;
    end
    assign bus.mem_dout = ram[ram_addr_q];

    // Model: tag store contents and expected responses in order.
    typedef struct {
        int            due;
        logic          hit;
        logic [AW-1:0] idx;
        logic [DW-1:0] old;
    } exp_t;
    exp_t          exp_q[$];
    logic [DW-1:0] exp_mem [1<<AW];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < (1<<AW); i++) exp_mem[i] = '0;
    endtask

    // Per-cycle response checker.
    always @(negedge clock) begin
        if (!reset) begin
            logic ev;
            ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            check("rsp_valid", bus.rsp_valid, ev);
            if (ev && bus.rsp_valid) begin
                check("model rsp_hit",   bus.rsp_hit,       exp_q[0].hit);
                check("model rsp_index", bus.rsp_index,     exp_q[0].idx);
                check("model rsp_old",   bus.rsp_old_entry, exp_q[0].old);
            end
            if (exp_q.size() > 0 && exp_q[0].due <= cyc) void'(exp_q.pop_front());
        end
    end

    // Present a request (called at a negedge) and run it through acceptance.
    task automatic issue(input logic [AW-1:0] idx, input logic [DW-2:0] tag, input logic alloc,
                         input logic exp_we, input logic [DW-1:0] exp_din);
        logic [DW-1:0] entry;
        logic          h;
        bus.req_index = idx;
        bus.req_tag   = tag;
        bus.req_alloc = alloc;
        bus.req_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (bus.req_ready) break;
            @(negedge clock);
        end
        if (!bus.req_ready) begin
            check("req_ready timeout", 0, 1);
            bus.req_valid = 1'b0;
            return;
        end
        entry = exp_mem[idx];
        h = entry[DW-1] && (entry[DW-2:0] == tag);
        if (!h && alloc) exp_mem[idx] = {1'b1, tag};
        last_due = cyc + 2;
        exp_q.push_back('{due: cyc + 2, hit: h, idx: idx, old: entry});
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        check("lookup mem_we", bus.mem_we, exp_we);
        if (exp_we) begin
            check("lookup mem_addr", bus.mem_addr, idx);
            check("lookup mem_din",  bus.mem_din,  exp_din);
        end
    endtask

    // Wait for the response and pin it against hand-computed values.
    task automatic wait_rsp(input logic [AW-1:0] idx, input logic hit, input logic [DW-1:0] old);
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (bus.rsp_valid) break;
        end
        if (!bus.rsp_valid) begin
            check("rsp timeout", 0, 1);
            return;
        end
        check("latency",       cyc,               last_due);
        check("lit rsp_hit",   bus.rsp_hit,       hit);
        check("lit rsp_index", bus.rsp_index,     idx);
        check("lit rsp_old",   bus.rsp_old_entry, old);
    endtask

    task automatic lookup(input logic [AW-1:0] idx, input logic [DW-2:0] tag, input logic alloc,
                          input logic hit, input logic [DW-1:0] old, input logic exp_we);
        issue(idx, tag, alloc, exp_we, {1'b1, tag});
        wait_rsp(idx, hit, old);
    endtask

    // Sweep: exactly 8 cycles writing 0 to addresses 0..7, then ready.
    task automatic check_sweep();
        for (int k = 0; k < 20; k++) begin
            if (bus.init_busy) break;
            @(negedge clock);
        end
        for (int i = 0; i < (1<<AW); i++) begin
            check("sweep init_busy", bus.init_busy, 1);
            check("sweep mem_we",    bus.mem_we,    1);
            check("sweep mem_addr",  bus.mem_addr,  i);
            check("sweep mem_din",   bus.mem_din,   0);
            check("sweep req_ready", bus.req_ready, 0);
            @(negedge clock);
        end
        check("post-sweep init_busy", bus.init_busy, 0);
        check("post-sweep req_ready", bus.req_ready, 1);
    endtask

    initial begin
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_index = '0;
        bus.req_tag   = '0;
        bus.req_alloc = 1'b0;
        model_clear();

        // 1: reset state, then the power-up sweep.
        repeat (2) @(negedge clock);
        check("reset init_busy", bus.init_busy,     1);
        check("reset mem_we",    bus.mem_we,        0);
        check("reset req_ready", bus.req_ready,     0);
        check("reset rsp_valid", bus.rsp_valid,     0);
        check("reset rsp_hit",   bus.rsp_hit,       0);
        check("reset rsp_index", bus.rsp_index,     0);
        check("reset rsp_old",   bus.rsp_old_entry, 0);
        @(posedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        check_sweep();

        // 2: plain miss, no write.
        lookup(3'd3, 6'h15, 1'b0, 1'b0, 7'h00, 1'b0);
        // 3: allocate miss writes 7'h55, immediate repeat hits.
        lookup(3'd3, 6'h15, 1'b1, 1'b0, 7'h00, 1'b1);
        lookup(3'd3, 6'h15, 1'b0, 1'b1, 7'h55, 1'b0);
        // 4: replace with a different tag.
        lookup(3'd3, 6'h2A, 1'b1, 1'b0, 7'h55, 1'b1);
        check("ram[3] after replace", ram[3], 7'h6A);
        // Other indices do not alias.
        lookup(3'd0, 6'h3F, 1'b1, 1'b0, 7'h00, 1'b1);
        lookup(3'd7, 6'h3F, 1'b0, 1'b0, 7'h00, 1'b0);
        lookup(3'd0, 6'h3F, 1'b0, 1'b1, 7'h7F, 1'b0);
        lookup(3'd3, 6'h2A, 1'b1, 1'b1, 7'h6A, 1'b0);

        // 5: flush during LOOKUP: response still arrives, then a sweep.
        issue(3'd3, 6'h2A, 1'b0, 1'b0, 7'h00);
        #1 bus.flush = 1'b1;
        @(posedge clock);
        #2 bus.flush = 1'b0;
        model_clear();
        wait_rsp(3'd3, 1'b1, 7'h6A);
        check("flush pending req_ready", bus.req_ready, 0);
        check_sweep();
        lookup(3'd3, 6'h2A, 1'b0, 1'b0, 7'h00, 1'b0);

        // 6: reset in the middle of an allocating LOOKUP.
        issue(3'd5, 6'h11, 1'b1, 1'b1, 7'h51);
        #1 reset = 1'b1;
        exp_q.delete();
        model_clear();
        #1;
        check("mid-reset mem_we",    bus.mem_we,    0);
        check("mid-reset rsp_valid", bus.rsp_valid, 0);
        @(posedge clock);
        #1 check("ram[5] not written", ram[5], 7'h00);
        @(posedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        check_sweep();
        lookup(3'd5, 6'h11, 1'b0, 1'b0, 7'h00, 1'b0);

        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
